// File: rtl/stream_3d_sub_to_1d_array.sv
// stream_3d_sub_to_1d_array
//   Captures a ROWS x COLS array on a valid/ready load port and streams it out
//   LANES elements per beat on a valid/ready output port.
//   Mode 0: bands of SUB_ROWS rows (last band may be shorter), column-major
//   inside each band. Mode 1: plain row-major.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   load handshake
//   in_array              element (r,c) is in_array[r][c]
//   in_mode               output order, sampled with the load
//   out_valid / out_ready beat handshake
//   out_data              stream element k at bits [(k%LANES)*BIT_WIDTH +: BIT_WIDTH]
//   out_last              current beat is the final beat of the array
//   busy                  streaming in progress
module stream_3d_sub_to_1d_array #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int SUB_ROWS  = 4,
  parameter int LANES     = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] in_array,
  input  logic                                     in_mode,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [LANES*BIT_WIDTH-1:0]               out_data,
  output logic                                     out_last,
  output logic                                     busy
);

  localparam int NumElems = ROWS * COLS;
  localparam int NumBeats = NumElems / LANES;
  // Row counters must hold a band base plus SUB_ROWS without wrapping.
  localparam int RowW     = $clog2(2 * ROWS + 1);
  localparam int RowIdxW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ColW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;

  if (ROWS < 1 || COLS < 1 || BIT_WIDTH < 1) begin : g_badShape
    $error("ROWS, COLS and BIT_WIDTH must be at least 1");
  end
  if (SUB_ROWS < 1 || SUB_ROWS > ROWS) begin : g_badSubRows
    $error("SUB_ROWS must lie in 1..ROWS");
  end
  if (LANES < 1 || (NumElems % LANES) != 0) begin : g_badLanes
    $error("LANES must divide ROWS*COLS");
  end

  typedef enum logic {IDLE, STREAM} StateT;

  StateT                                   r_state;
  StateT                                   w_nextState;
  logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] r_buf;
  logic                                    r_mode;
  logic [RowW-1:0]                         r_row;
  logic [ColW-1:0]                         r_col;
  logic [RowW-1:0]                         r_bandBase;
  logic [BeatW-1:0]                        r_beat;

  logic                                    w_load;
  logic                                    w_accept;
  logic [RowW-1:0]                         w_rowStep;
  logic [ColW-1:0]                         w_colStep;
  logic [RowW-1:0]                         w_baseStep;
  logic [RowW-1:0]                         w_bandTop;
  logic [LANES*BIT_WIDTH-1:0]              w_beatData;

  // State register; reset parks the block in IDLE, aborting any stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and handshake outputs. in_ready is gated by rst so the block
  // refuses loads for as long as reset is held.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    busy        = 1'b0;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !rst;
        w_load   = in_valid && !rst;
        if (w_load) begin
          w_nextState = STREAM;
        end
      end
      STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = w_beatData;
        out_last  = (r_beat == BeatW'(NumBeats - 1));
        w_accept  = out_ready;
        if (w_accept && out_last) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Walk the output order LANES steps from the current position. Each lane
  // reads the element at the walk position, then the walk advances one step;
  // the final position becomes the next beat's start. Band height is clipped
  // against ROWS with a compare, so no division is needed.
  always_comb begin
    w_rowStep  = r_row;
    w_colStep  = r_col;
    w_baseStep = r_bandBase;
    w_bandTop  = '0;
    w_beatData = '0;
    for (int k = 0; k < LANES; k++) begin
      w_beatData[k*BIT_WIDTH +: BIT_WIDTH] = r_buf[w_rowStep[RowIdxW-1:0]][w_colStep];
      w_bandTop = w_baseStep + RowW'(SUB_ROWS);
      if (w_bandTop > RowW'(ROWS)) begin
        w_bandTop = RowW'(ROWS);
      end
      if (!r_mode) begin
        if (w_rowStep + 1'b1 < w_bandTop) begin
          w_rowStep = w_rowStep + 1'b1;
        end else begin
          if (w_colStep == ColW'(COLS - 1)) begin
            w_colStep  = '0;
            w_baseStep = w_baseStep + RowW'(SUB_ROWS);
          end else begin
            w_colStep = w_colStep + 1'b1;
          end
          w_rowStep = w_baseStep;
        end
      end else begin
        if (w_colStep == ColW'(COLS - 1)) begin
          w_colStep = '0;
          w_rowStep = w_rowStep + 1'b1;
        end else begin
          w_colStep = w_colStep + 1'b1;
        end
      end
    end
  end

  // Position counters and captured mode: cleared on load, advanced only when
  // a beat is accepted so backpressure holds the current beat steady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_bandBase <= '0;
      r_beat     <= '0;
    end else if (w_load) begin
      r_mode     <= in_mode;
      r_row      <= '0;
      r_col      <= '0;
      r_bandBase <= '0;
      r_beat     <= '0;
    end else if (w_accept) begin
      r_row      <= w_rowStep;
      r_col      <= w_colStep;
      r_bandBase <= w_baseStep;
      r_beat     <= r_beat + 1'b1;
    end
  end

  // Array buffer carries no reset; it is only meaningful after a load.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_buf <= in_array;
    end
  end

endmodule

// File: tb/tb_stream_3d_sub_to_1d_array.sv
// tb_stream_3d_sub_to_1d_array
//   Directed bench for stream_3d_sub_to_1d_array. dutA is the 8x8, 8-bit,
//   single-lane configuration; dutB is 6x2 with a partial second band and
//   two lanes per beat. Inputs are driven and outputs sampled on the falling
//   edge, away from the active rising edge.
module tb_stream_3d_sub_to_1d_array;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic                 aInValid, aInReady, aInMode;
  logic                 aOutValid, aOutReady, aOutLast, aBusy;
  logic [7:0][7:0][7:0] aInArray;
  logic [7:0][7:0][7:0] patA;
  logic [7:0]           aOutData;

  logic                 bInValid, bInReady, bInMode;
  logic                 bOutValid, bOutReady, bOutLast, bBusy;
  logic [5:0][1:0][7:0] bInArray;
  logic [15:0]          bOutData;

  logic [7:0]           expQ [64];
  logic [15:0]          expB [6];

  stream_3d_sub_to_1d_array #(
    .BIT_WIDTH(8), .ROWS(8), .COLS(8), .SUB_ROWS(4), .LANES(1)
  ) dutA (
    .clk(clk), .rst(rst),
    .in_valid(aInValid), .in_ready(aInReady), .in_array(aInArray), .in_mode(aInMode),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
    .out_last(aOutLast), .busy(aBusy)
  );

  stream_3d_sub_to_1d_array #(
    .BIT_WIDTH(8), .ROWS(6), .COLS(2), .SUB_ROWS(4), .LANES(2)
  ) dutB (
    .clk(clk), .rst(rst),
    .in_valid(bInValid), .in_ready(bInReady), .in_array(bInArray), .in_mode(bInMode),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
    .out_last(bOutLast), .busy(bBusy)
  );

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected dutA order: mode 0 walks bands of 4 rows column-major, mode 1
  // is row-major. Element (r,c) holds r*8+c.
  task automatic buildExpected(input bit mode);
    int n = 0;
    if (!mode) begin
      for (int b = 0; b * 4 < 8; b++)
        for (int c = 0; c < 8; c++)
          for (int r = b * 4; r < b * 4 + 4 && r < 8; r++) begin
            expQ[n] = 8'(r * 8 + c);
            n++;
          end
    end else begin
      for (int i = 0; i < 64; i++) expQ[i] = 8'(i);
    end
  endtask

  // Load patA into dutA with the given mode; first beat must follow at once.
  task automatic applyStimulus(input bit mode);
    @(negedge clk);
    checkOutput("load in_ready", 32'(aInReady), 32'd1);
    aInArray = patA;
    aInMode  = mode;
    aInValid = 1'b1;
    @(negedge clk);
    aInValid = 1'b0;
    checkOutput("first beat out_valid", 32'(aOutValid), 32'd1);
    checkOutput("stream busy", 32'(aBusy), 32'd1);
    checkOutput("stream in_ready", 32'(aInReady), 32'd0);
  endtask

  // Drain dutA against expQ. Optional random out_ready, a 5-cycle stall at
  // beat stallAt, an asynchronous reset at beat abortAt, and poking of the
  // load port with different data while streaming.
  task automatic runStreamA(input bit randReady, input int stallAt,
                            input int abortAt, input bit poke);
    int         idx = 0;
    int         cyc = 0;
    int         stallLeft = 0;
    bit         stallDone = 1'b0;
    bit         stalled = 1'b0;
    bit         rdy;
    logic [7:0] heldData = '0;
    logic       heldLast = 1'b0;
    while (idx < 64 && cyc < 3000) begin
      aInValid = 1'b0;
      if (idx == abortAt) begin
        #2 rst = 1'b1;
        #1;
        checkOutput("abort out_valid", 32'(aOutValid), 32'd0);
        checkOutput("abort busy", 32'(aBusy), 32'd0);
        checkOutput("abort in_ready", 32'(aInReady), 32'd0);
        checkOutput("abort out_last", 32'(aOutLast), 32'd0);
        checkOutput("abort out_data", 32'(aOutData), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (stalled) begin
        checkOutput("stall data hold", 32'(aOutData), 32'(heldData));
        checkOutput("stall last hold", 32'(aOutLast), 32'(heldLast));
      end
      if (!stallDone && idx == stallAt) begin
        stallLeft = 5;
        stallDone = 1'b1;
      end
      if (stallLeft > 0) begin
        rdy = 1'b0;
        stallLeft--;
      end else if (randReady) begin
        rdy = 1'($urandom_range(0, 1));
      end else begin
        rdy = 1'b1;
      end
      aOutReady = rdy;
      if (aOutValid !== 1'b1) begin
        checkOutput("stream out_valid", 32'(aOutValid), 32'd1);
        break;
      end
      if (rdy) begin
        checkOutput($sformatf("beat %0d data", idx), 32'(aOutData), 32'(expQ[idx]));
        checkOutput($sformatf("beat %0d last", idx), 32'(aOutLast), 32'(idx == 63));
        idx++;
        stalled = 1'b0;
      end else begin
        heldData = aOutData;
        heldLast = aOutLast;
        stalled  = 1'b1;
      end
      if (poke && (cyc % 5 == 2)) begin
        aInValid = 1'b1;
        aInArray = ~patA;
        aInMode  = ~aInMode;
      end
      @(negedge clk);
      cyc++;
    end
    aInValid  = 1'b0;
    aOutReady = 1'b1;
    checkOutput("stream beat count", 32'(idx), 32'd64);
    checkOutput("end out_valid", 32'(aOutValid), 32'd0);
    checkOutput("end in_ready", 32'(aInReady), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    aInValid  = 1'b0;
    aInMode   = 1'b0;
    aOutReady = 1'b1;
    bInValid  = 1'b0;
    bInMode   = 1'b0;
    bOutReady = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) patA[r][c] = 8'(r * 8 + c);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 2; c++) bInArray[r][c] = 8'(r * 2 + c);
    aInArray = patA;
    // {lane1, lane0} for the order 0,2,4,6,1,3,5,7,8,10,9,11
    expB[0] = 16'h0200;
    expB[1] = 16'h0604;
    expB[2] = 16'h0301;
    expB[3] = 16'h0705;
    expB[4] = 16'h0A08;
    expB[5] = 16'h0B09;

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 32'(aInReady), 32'd0);
    checkOutput("reset out_valid", 32'(aOutValid), 32'd0);
    checkOutput("reset busy", 32'(aBusy), 32'd0);
    checkOutput("reset out_last", 32'(aOutLast), 32'd0);
    checkOutput("reset out_data", 32'(aOutData), 32'd0);
    rst = 1'b0;

    $display("[TB] 8x8 mode 0, out_ready high");
    buildExpected(1'b0);
    applyStimulus(1'b0);
    runStreamA(1'b0, -1, -1, 1'b0);

    $display("[TB] 6x2 partial band, two lanes");
    @(negedge clk);
    checkOutput("B load in_ready", 32'(bInReady), 32'd1);
    bInValid = 1'b1;
    @(negedge clk);
    bInValid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      checkOutput($sformatf("B beat %0d valid", j), 32'(bOutValid), 32'd1);
      checkOutput($sformatf("B beat %0d data", j), 32'(bOutData), 32'(expB[j]));
      checkOutput($sformatf("B beat %0d last", j), 32'(bOutLast), 32'(j == 5));
      @(negedge clk);
    end
    checkOutput("B end out_valid", 32'(bOutValid), 32'd0);
    checkOutput("B end in_ready", 32'(bInReady), 32'd1);

    $display("[TB] 8x8 mode 1");
    buildExpected(1'b1);
    applyStimulus(1'b1);
    runStreamA(1'b0, -1, -1, 1'b0);

    $display("[TB] 8x8 mode 0 with backpressure and ignored loads");
    buildExpected(1'b0);
    applyStimulus(1'b0);
    runStreamA(1'b1, 10, -1, 1'b1);

    $display("[TB] reset at beat 20, then reload");
    applyStimulus(1'b0);
    runStreamA(1'b0, -1, 20, 1'b0);
    applyStimulus(1'b0);
    runStreamA(1'b0, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_3d_sub_to_1d_array.md
Name: stream_3d_sub_to_1d_array

Overview:
- Sequential successor to the combinational sub-block flattener. Accepts a ROWS x COLS element array on a valid/ready load port and streams it out as LANES elements per beat on a valid/ready output port.
- Output order is selectable per load:
  - mode 0: row bands of SUB_ROWS rows, column-major inside each band, with a partial last band supported.
  - mode 1: plain row-major.
- Sits between array producers (accumulators, tile buffers) and narrow serial consumers.

Parameters:
- BIT_WIDTH, 4, bits per element.
- ROWS, 8, array rows.
- COLS, 8, array columns.
- SUB_ROWS, 4, band height for mode 0. Legal range 1..ROWS. ROWS need not be a multiple of SUB_ROWS.
- LANES, 1, elements per output beat. Must divide ROWS*COLS.
- Illegal parameter combinations are an elaboration-time error.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  load request
- in_ready  output  1  block can accept a load
- in_array  input  [BIT_WIDTH-1:0] x [ROWS-1:0][COLS-1:0]  array to stream; element (r,c) is in_array[r][c]
- in_mode  input  1  0 = banded column-major, 1 = row-major; sampled with the load
- out_valid  output  1  out_data holds a valid beat
- out_ready  input  1  consumer accepts the beat
- out_data  output  LANES*BIT_WIDTH  beat payload; stream element k sits at bits [(k%LANES)*BIT_WIDTH +: BIT_WIDTH]
- out_last  output  1  current beat is the final beat of the array
- busy  output  1  streaming in progress

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- State machine, IDLE and STREAM:
  - Reset forces IDLE. While rst is high: in_ready=0, out_valid=0, out_last=0, busy=0, out_data=0, all counters 0. The buffer is not reset.
  - IDLE: in_ready=1, out_valid=0. Load fires when in_valid&&in_ready. On that edge: capture in_array and in_mode, clear counters, go to STREAM.
  - STREAM: in_ready=0, busy=1, out_valid=1. First beat is valid the cycle after the load edge (latency 1).
  - A beat advances only on out_valid&&out_ready.
  - Acceptance of the beat with out_last=1 returns to IDLE. in_ready=1 the following cycle; there is no same-cycle reload.
- Ordering, mode 0:
  - Band b covers rows b*SUB_ROWS .. b*SUB_ROWS+H-1, where H=min(SUB_ROWS, ROWS-b*SUB_ROWS).
  - Within a band, for c=0..COLS-1, emit r=band start .. band start+H-1.
  - Bands are emitted in ascending order.
  - Implement with row/col/band counters. No divider.
- Ordering, mode 1: r=0..ROWS-1, c=0..COLS-1, c fastest.
- Beats: N=ROWS*COLS elements form N/LANES beats. Beat j carries elements j*LANES .. j*LANES+LANES-1.
- out_last=1 only while out_valid and the current beat is beat N/LANES-1.
- Backpressure: while out_valid&&!out_ready, out_data and out_last hold stable. No element is skipped or duplicated.
- out_data=0 whenever out_valid=0.
- in_valid while not in IDLE is ignored. The captured data and mode are unaffected by in_array/in_mode changes during STREAM.
- Reset mid-stream aborts the stream: IDLE, partial output discarded, no out_last.
- Degenerate parameters:
  - SUB_ROWS=ROWS: mode 0 is pure column-major.
  - SUB_ROWS=1: mode 0 equals row-major.
  - LANES=ROWS*COLS: a single beat, with out_last=1 on that beat.
- Throughput with out_ready held high: one load every N/LANES+1 cycles.

Test Plan:
- BIT_WIDTH=8, defaults, in[r][c]=r*8+c, mode 0, out_ready=1. Expect 64 beats: 0,8,16,24,1,9,17,25,…,31; then 32,40,48,56,33,…,63. out_last only on the value-63 beat. in_ready returns 1 one cycle later.
- ROWS=6, COLS=2, SUB_ROWS=4, BIT_WIDTH=8, in[r][c]=r*2+c, mode 0. Expect 0,2,4,6,1,3,5,7,8,10,9,11 (partial last band).
- Same configuration with LANES=2. Expect 6 beats; beat0 lane0=0, lane1=2; beat5 lane0=9, lane1=11 with out_last=1.
- Defaults with mode 1. Expect 0,1,2,…,63.
- Mode 0 run with out_ready toggled pseudo-randomly and held low 5 cycles at beat 10. Expect out_data stable while stalled and the full ordered sequence intact. in_valid pulses with changed in_array during STREAM have no effect.
- Assert rst asynchronously at beat 20. Expect out_valid/busy low immediately and IDLE. A new load then streams from element 0 with correct order.
